io_tx_port: RTL and testbench

- Memory-mapped output peripheral that responds to processor bus cycles on the shared clock/we/address/data bus.
- Processor stores bytes into a transmit register; the block buffers them in a FIFO and hands them to an external consumer over a valid/ready stream.
- Sits beside the program RAM on the same bus. The RAM decode must exclude the BASE..BASE+3 window so that exactly one device drives data.

---
 rtl/io_tx_port_if.sv | 19 +
 rtl/io_tx_port.sv | 115 +++++++++++
 tb/tb_io_tx_port.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/io_tx_port_if.sv
// Processor address/strobe plus the outbound byte stream of io_tx_port.
// The shared data bus is tri-state and stays a plain inout port on the module.
interface io_tx_port_if;
   logic       we;
   logic [7:0] address;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output we, address, out_ready,
      input  out_data, out_valid
   );

   modport slave (
      input  we, address, out_ready,
      output out_data, out_valid
   );
endinterface

// File: rtl/io_tx_port.sv
// Bus-mapped transmit port: stores into TXDATA go through a fall-through FIFO to a valid/ready stream.
// A byte written at edge N is presented after edge N; out_ready low holds the head, and a full FIFO rejects pushes and sets overflow.
module io_tx_port #(
   parameter logic [7:0] BASE  = 8'hF0,
   parameter int         DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   io_tx_port_if.slave bus,
   inout  wire  [7:0]  data
);
   localparam int         AW      = (DEPTH <= 2) ? 1 : (DEPTH <= 4) ? 2 : 3;
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [3:0]    r_count;
   logic          r_ovf;
   logic          r_en;
   logic [7:0]    r_last;

   logic       w_sel;
   logic [1:0] w_off;
   logic       w_wr;
   logic       w_push_req;
   logic       w_push_ok;
   logic       w_pop;
   logic       w_flush;
   logic       w_ovf_clr;
   logic       w_out_valid;
   logic       w_empty;
   logic       w_full;
   logic [7:0] w_rd_dat;

   assign w_sel      = (bus.address[7:2] == BASE[7:2]);
   assign w_off      = bus.address[1:0];
   assign w_wr       = w_sel && bus.we;
   assign w_push_req = w_wr && (w_off == 2'd0);
   assign w_flush    = w_wr && (w_off == 2'd2) && data[1];
   assign w_ovf_clr  = w_wr && (w_off == 2'd1) && data[2];

   assign w_empty     = (r_count == 4'd0);
   assign w_full      = (r_count == DEPTH_C);
   assign w_out_valid = r_en && !w_empty;
   assign w_pop       = w_out_valid && bus.out_ready;
   // A pop in the same edge frees a slot, so a full FIFO can still take the byte.
   assign w_push_ok   = w_push_req && (!w_full || w_pop);

   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_valid ? r_mem[r_rp] : 8'h00;

   always_comb begin
      w_rd_dat = 8'h00;
      case (w_off)
         2'd0:    w_rd_dat = r_last;
         2'd1:    w_rd_dat = {r_count, r_en, r_ovf, w_full, w_empty};
         2'd2:    w_rd_dat = {7'd0, r_en};
         default: w_rd_dat = 8'h00;
      endcase
   end

   assign data = (w_sel && !bus.we) ? w_rd_dat : 8'bz;

   always_ff @(posedge clock) begin
      if (reset && w_push_ok) begin
         r_mem[r_wp] <= data;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= 4'd0;
         r_ovf   <= 1'b0;
         r_en    <= 1'b1;
         r_last  <= 8'h00;
      end else begin
         // Flush wins over a concurrent pop; it can never meet a push (different offsets).
         if (w_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= 4'd0;
         end else begin
            if (w_push_ok) begin
               r_wp <= r_wp + PTR_ONE;
            end
            if (w_pop) begin
               r_rp <= r_rp + PTR_ONE;
            end
            if (w_push_ok && !w_pop) begin
               r_count <= r_count + 4'd1;
            end else if (!w_push_ok && w_pop) begin
               r_count <= r_count - 4'd1;
            end
         end

         if (w_push_ok) begin
            r_last <= data;
         end

         if (w_push_req && !w_push_ok) begin
            r_ovf <= 1'b1;
         end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
         end

         if (w_wr && (w_off == 2'd2)) begin
            r_en <= data[0];
         end
      end
   end
endmodule

// File: tb/tb_io_tx_port.sv
// Directed and random checks of io_tx_port against a queue-based model of the register map and FIFO.
module tb_io_tx_port;
   localparam int DEPTH = 8;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   io_tx_port_if bus ();
   wire  [7:0] data;
   logic       tb_drv;
   logic [7:0] tb_dat;
   assign data = tb_drv ? tb_dat : 8'bz;

   io_tx_port #(.BASE(8'hF0), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .data  (data)
   );

   logic [7:0] q [$];
   logic       m_ovf;
   logic       m_en;
   logic [7:0] m_last;
   int         n_chk = 0;
   int         n_fail = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] reg_exp(input logic [7:0] a);
      if (a[7:2] != 6'h3C) return 8'bz;
      case (a[1:0])
         2'd0:    return m_last;
         2'd1:    return {4'(q.size()), m_en, m_ovf, q.size() == DEPTH, q.size() == 0};
         2'd2:    return {7'd0, m_en};
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      q.delete();
      m_ovf  = 1'b0;
      m_en   = 1'b1;
      m_last = 8'h00;
   endtask

   // Combinational register read between edges; no clock edge occurs inside.
   task automatic rd(input logic [7:0] a, input string tag);
      bus.we        = 1'b0;
      tb_drv        = 1'b0;
      bus.out_ready = 1'b0;
      bus.address   = a;
      #1;
      chk(tag, data, reg_exp(a));
   endtask

   task automatic cyc(input logic rst, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic rdy);
      logic pop;
      logic sel;
      @(negedge clock);
      reset         = rst;
      bus.we        = w;
      bus.address   = a;
      tb_drv        = w;
      tb_dat        = d;
      bus.out_ready = rdy;
      #1;
      chk("out_valid", {7'd0, bus.out_valid}, {7'd0, m_en && q.size() != 0});
      if (m_en && q.size() != 0) chk("out_data", bus.out_data, q[0]);
      pop = rdy && m_en && (q.size() != 0);
      sel = (a[7:2] == 6'h3C);
      @(posedge clock);
      if (!rst) begin
         model_reset();
      end else begin
         if (w && sel && a[1:0] == 2'd2 && d[1]) q.delete();
         else if (pop) void'(q.pop_front());
         if (w && sel && a[1:0] == 2'd0) begin
            if (q.size() < DEPTH) begin
               q.push_back(d);
               m_last = d;
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (w && sel && a[1:0] == 2'd1 && d[2]) m_ovf = 1'b0;
         if (w && sel && a[1:0] == 2'd2) m_en = d[0];
      end
      #1;
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 8'h10, 8'h00, rdy);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   logic [7:0] addr_tbl [8];

   initial begin
      reset         = 1'b0;
      bus.we        = 1'b0;
      bus.address   = 8'h10;
      bus.out_ready = 1'b0;
      tb_drv        = 1'b0;
      tb_dat        = 8'h00;
      model_reset();
      repeat (2) @(posedge clock);
      #1;

      cyc(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
      rd(8'hF1, "reset_status");
      rd(8'hF0, "reset_txdata");
      rd(8'h10, "unselected_hiz");
      chk("reset_valid", {7'd0, bus.out_valid}, 8'h00);

      foreach (tb_dat[i]) begin end
      cyc(1'b1, 1'b1, 8'hF0, 8'h11, 1'b0);
      cyc(1'b1, 1'b1, 8'hF0, 8'h22, 1'b0);
      cyc(1'b1, 1'b1, 8'hF0, 8'h33, 1'b0);
      rd(8'hF1, "status_three");
      chk("head_11", bus.out_data, 8'h11);
      idle(1'b1, 4);
      rd(8'hF1, "status_drained");

      for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b1, 8'hF0, 8'(i), 1'b0);
      rd(8'hF1, "status_overflow");
      rd(8'hF0, "last_accepted");
      idle(1'b1, 9);
      rd(8'hF1, "status_after_drain");
      cyc(1'b1, 1'b1, 8'hF1, 8'h04, 1'b0);
      rd(8'hF1, "overflow_cleared");

      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 8'hF0, 8'h40 + 8'(i), 1'b0);
      cyc(1'b1, 1'b1, 8'hF0, 8'hAA, 1'b1);
      rd(8'hF1, "full_push_pop");
      idle(1'b1, DEPTH + 1);

      cyc(1'b1, 1'b1, 8'hF0, 8'h5A, 1'b0);
      cyc(1'b1, 1'b1, 8'hF0, 8'hA5, 1'b0);
      cyc(1'b1, 1'b1, 8'hF2, 8'h00, 1'b0);
      chk("disabled_valid", {7'd0, bus.out_valid}, 8'h00);
      idle(1'b1, 2);
      rd(8'hF1, "disabled_held");
      cyc(1'b1, 1'b1, 8'hF2, 8'h03, 1'b1);
      rd(8'hF2, "ctrl_after_flush");
      rd(8'hF1, "status_after_flush");

      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'hF0, 8'hC0 + 8'(i), 1'b0);
      cyc(1'b1, 1'b1, 8'hF0, 8'hF0, 1'b0);
      cyc(1'b0, 1'b1, 8'hF0, 8'h55, 1'b1);
      rd(8'hF0, "reset_mid_txdata");
      rd(8'hF1, "reset_mid_status");
      idle(1'b0, 1);

      addr_tbl = '{8'hF0, 8'hF0, 8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'h10, 8'hF4};
      for (int i = 0; i < 400; i++) begin
         logic [7:0] a;
         logic [7:0] d;
         a = addr_tbl[$urandom_range(0, 7)];
         d = 8'($urandom);
         if (a == 8'hF2) d[1] = ($urandom_range(0, 7) == 0);
         if (a == 8'hF2 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         cyc(($urandom_range(0, 79) != 0), $urandom_range(0, 1) == 1, a, d,
             $urandom_range(0, 3) == 0);
         rd(addr_tbl[$urandom_range(0, 7)], "random_read");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
